// File: rtl/pht_pkg.sv
// Shared types and counter arithmetic for the pattern-history-table controller.
package pht_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } pht_state_e;

    // Weakly not-taken: the largest value whose MSB is still clear.
    function automatic logic [31:0] ctr_init(input int unsigned nbits);
        return (32'd1 << (nbits - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] ctr_next(input logic [31:0] ctr,
                                             input logic taken,
                                             input int unsigned nbits);
        logic [31:0] max_v;
        max_v = (32'd1 << nbits) - 32'd1;
        if (taken) begin
            return (ctr >= max_v) ? max_v : ctr + 32'd1;
        end
        return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
    endfunction

endpackage

// File: rtl/pht_counter_ctrl_if.sv
// Predictor-side bus: a prediction channel and a training (update) channel.
// Handshake: a transfer happens in a cycle where both val and rdy are high; the master holds
// val and its payload stable until it sees rdy, and rdy never depends on a later cycle's val.
interface pht_counter_ctrl_if #(
    parameter int unsigned p_idx_nbits = 8
) ();
    logic                   pred_val;
    logic                   pred_rdy;
    logic [p_idx_nbits-1:0] pred_idx;
    logic                   pred_taken;
    logic                   upd_val;
    logic                   upd_rdy;
    logic [p_idx_nbits-1:0] upd_idx;
    logic                   upd_taken;

    modport master (
        output pred_val, pred_idx, upd_val, upd_idx, upd_taken,
        input  pred_rdy, pred_taken, upd_rdy
    );

    modport slave (
        input  pred_val, pred_idx, upd_val, upd_idx, upd_taken,
        output pred_rdy, pred_taken, upd_rdy
    );
endinterface

// File: rtl/pht_ctr_next.sv
// Combinational saturating counter step: increments on taken, decrements on not-taken.
module pht_ctr_next
    import pht_pkg::*;
#(
    parameter int unsigned p_ctr_nbits = 2
) (
    input  logic [p_ctr_nbits-1:0] ctr_i,
    input  logic                   taken_i,
    output logic [p_ctr_nbits-1:0] nxt_o
);
    assign nxt_o = p_ctr_nbits'(ctr_next(32'(ctr_i), taken_i, p_ctr_nbits));
endmodule

// File: rtl/pht_rf_1r1w.sv
// One-read one-write register file: asynchronous read, write on the rising edge, no reset.
module pht_rf_1r1w #(
    parameter int unsigned p_depth = 256,
    parameter int unsigned p_width = 2,
    localparam int unsigned c_addr_nbits = $clog2(p_depth)
) (
    input  logic                    clk,
    input  logic                    we_i,
    input  logic [c_addr_nbits-1:0] waddr_i,
    input  logic [p_width-1:0]      wdata_i,
    input  logic [c_addr_nbits-1:0] raddr_i,
    output logic [p_width-1:0]      rdata_o
);
    logic [p_width-1:0] mem_q [p_depth];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/pht_counter_ctrl.sv
// PHT controller: init sweep, zero-latency predictions, one-entry update buffer with starvation guard.
// Optional feature macro PHT_STATS_EN adds drain and forced-cycle counters.
module pht_counter_ctrl
    import pht_pkg::*;
#(
    parameter int unsigned p_num_entries = 256,
    parameter int unsigned p_ctr_nbits   = 2,
    parameter int unsigned p_max_stall   = 4,
    localparam int unsigned c_idx_nbits  = $clog2(p_num_entries)
) (
    input  logic                 clk,
    input  logic                 reset,
    pht_counter_ctrl_if.slave    bus,
    output logic                 init_done,
    output pht_state_e           dbg_state_o
`ifdef PHT_STATS_EN
    ,
    output logic [31:0]          stat_upd_cnt,
    output logic [31:0]          stat_force_cnt
`endif
);
    localparam int unsigned c_stall_nbits = (p_max_stall < 1) ? 1 : $clog2(p_max_stall + 1);
    localparam logic [p_ctr_nbits-1:0]   C_INIT      = p_ctr_nbits'(ctr_init(p_ctr_nbits));
    localparam logic [c_idx_nbits-1:0]   C_LAST      = c_idx_nbits'(p_num_entries - 1);
    localparam logic [c_stall_nbits-1:0] C_MAX_STALL = c_stall_nbits'(p_max_stall);

    pht_state_e               state_q, state_d;
    logic [c_idx_nbits-1:0]   sweep_ptr_q, sweep_ptr_d;
    logic                     buf_full_q, buf_full_d;
    logic [c_idx_nbits-1:0]   buf_idx_q, buf_idx_d;
    logic                     buf_taken_q, buf_taken_d;
    logic [c_stall_nbits-1:0] stall_cnt_q, stall_cnt_d;

    logic                     run_c, force_c, drain_c;
    logic                     rf_we;
    logic [c_idx_nbits-1:0]   rf_waddr, rf_raddr;
    logic [p_ctr_nbits-1:0]   rf_wdata, rf_rdata, ctr_nxt;

    // Outputs are forced low during reset even if the registers still hold RUN.
    assign run_c   = (state_q == RUN) && !reset;
    assign force_c = run_c && buf_full_q && (stall_cnt_q == C_MAX_STALL);
    assign drain_c = run_c && buf_full_q && (!bus.pred_val || force_c);

    // The single read port serves the drain when it happens, predictions otherwise.
    assign rf_raddr       = drain_c ? buf_idx_q : bus.pred_idx;
    assign bus.pred_rdy   = run_c && !force_c;
    assign bus.pred_taken = bus.pred_val && bus.pred_rdy && rf_rdata[p_ctr_nbits-1];
    assign bus.upd_rdy    = run_c && !buf_full_q;
    assign init_done      = run_c;
    assign dbg_state_o    = state_q;

    pht_rf_1r1w #(
        .p_depth (p_num_entries),
        .p_width (p_ctr_nbits)
    ) u_rf (
        .clk     (clk),
        .we_i    (rf_we),
        .waddr_i (rf_waddr),
        .wdata_i (rf_wdata),
        .raddr_i (rf_raddr),
        .rdata_o (rf_rdata)
    );

    pht_ctr_next #(
        .p_ctr_nbits (p_ctr_nbits)
    ) u_ctr_next (
        .ctr_i   (rf_rdata),
        .taken_i (buf_taken_q),
        .nxt_o   (ctr_nxt)
    );

    always_comb begin
        state_d     = state_q;
        sweep_ptr_d = sweep_ptr_q;
        buf_full_d  = buf_full_q;
        buf_idx_d   = buf_idx_q;
        buf_taken_d = buf_taken_q;
        stall_cnt_d = stall_cnt_q;
        rf_we       = 1'b0;
        rf_waddr    = sweep_ptr_q;
        rf_wdata    = C_INIT;
        case (state_q)
            INIT: begin
                rf_we       = !reset;
                sweep_ptr_d = sweep_ptr_q + c_idx_nbits'(1);
                if (sweep_ptr_q == C_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (drain_c) begin
                    rf_we       = 1'b1;
                    rf_waddr    = buf_idx_q;
                    rf_wdata    = ctr_nxt;
                    buf_full_d  = 1'b0;
                    stall_cnt_d = '0;
                end else if (buf_full_q && bus.pred_val) begin
                    stall_cnt_d = stall_cnt_q + c_stall_nbits'(1);
                end
                if (bus.upd_val && bus.upd_rdy) begin
                    buf_full_d  = 1'b1;
                    buf_idx_d   = bus.upd_idx;
                    buf_taken_d = bus.upd_taken;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT;
            sweep_ptr_q <= '0;
            buf_full_q  <= 1'b0;
            buf_idx_q   <= '0;
            buf_taken_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_ptr_q <= sweep_ptr_d;
            buf_full_q  <= buf_full_d;
            buf_idx_q   <= buf_idx_d;
            buf_taken_q <= buf_taken_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

`ifdef PHT_STATS_EN
    logic [31:0] stat_upd_q, stat_force_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_upd_q   <= '0;
            stat_force_q <= '0;
        end else begin
            if (drain_c) stat_upd_q   <= stat_upd_q + 32'd1;
            if (force_c) stat_force_q <= stat_force_q + 32'd1;
        end
    end

    assign stat_upd_cnt   = reset ? '0 : stat_upd_q;
    assign stat_force_cnt = reset ? '0 : stat_force_q;
`endif
endmodule

// File: tb/tb_pht_counter_ctrl.sv
// Bench for pht_counter_ctrl: directed scenarios plus a random run against a behavioural model.
module tb_pht_counter_ctrl;
    import pht_pkg::*;

    localparam int N  = 8;
    localparam int W  = 2;
    localparam int MS = 4;
    localparam int IW = 3;
    localparam int CTR_MAX  = (1 << W) - 1;
    localparam int CTR_INIT = (1 << (W - 1)) - 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       init_done;
    pht_state_e dbg_state;
`ifdef PHT_STATS_EN
    logic [31:0] stat_upd_cnt, stat_force_cnt;
`endif

    pht_counter_ctrl_if #(.p_idx_nbits(IW)) bus ();

    pht_counter_ctrl #(
        .p_num_entries (N),
        .p_ctr_nbits   (W),
        .p_max_stall   (MS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .init_done      (init_done),
        .dbg_state_o    (dbg_state)
`ifdef PHT_STATS_EN
        ,
        .stat_upd_cnt   (stat_upd_cnt),
        .stat_force_cnt (stat_force_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: counter values as plain integers, the buffer as a pending record.
    int          mdl_ctr [N];
    int          mdl_init_cnt;
    bit          mdl_buf_full;
    int          mdl_buf_idx;
    bit          mdl_buf_taken;
    int          mdl_stall;
    int unsigned mdl_upd_cnt;
    int unsigned mdl_force_cnt;

    logic obs_init, obs_prdy, obs_pt, obs_urdy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic reset_dut(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            reset         = 1'b1;
            bus.pred_val  = 1'b1;
            bus.pred_idx  = IW'($urandom_range(0, N - 1));
            bus.upd_val   = 1'b1;
            bus.upd_idx   = IW'($urandom_range(0, N - 1));
            bus.upd_taken = 1'b1;
            @(negedge clk);
            check("rst_init_done", init_done, 0);
            check("rst_pred_rdy", bus.pred_rdy, 0);
            check("rst_pred_taken", bus.pred_taken, 0);
            check("rst_upd_rdy", bus.upd_rdy, 0);
`ifdef PHT_STATS_EN
            check("rst_stat_upd", stat_upd_cnt, 0);
            check("rst_stat_force", stat_force_cnt, 0);
`endif
            @(posedge clk);
            #1;
        end
        reset         = 1'b0;
        bus.pred_val  = 1'b0;
        bus.upd_val   = 1'b0;
        mdl_init_cnt  = 0;
        mdl_buf_full  = 0;
        mdl_stall     = 0;
        mdl_upd_cnt   = 0;
        mdl_force_cnt = 0;
        for (int i = 0; i < N; i++) mdl_ctr[i] = -1;
    endtask

    // One clock: drive inputs, compare every output with the model at the falling edge, advance the model.
    task automatic cycle(input bit pv, input int pi, input bit uv, input int ui, input bit ut);
        bit run, frc, drain, e_prdy, e_urdy, e_pt;
        bus.pred_val  = pv;
        bus.pred_idx  = IW'(pi);
        bus.upd_val   = uv;
        bus.upd_idx   = IW'(ui);
        bus.upd_taken = ut;
        run    = (mdl_init_cnt >= N);
        frc    = run && mdl_buf_full && (mdl_stall == MS);
        e_prdy = run && !frc;
        e_urdy = run && !mdl_buf_full;
        e_pt   = pv && e_prdy && (mdl_ctr[pi] > CTR_INIT);
        drain  = run && mdl_buf_full && (!pv || frc);
        @(negedge clk);
        obs_init = init_done;
        obs_prdy = bus.pred_rdy;
        obs_pt   = bus.pred_taken;
        obs_urdy = bus.upd_rdy;
        check("init_done", obs_init, run);
        check("pred_rdy", obs_prdy, e_prdy);
        check("pred_taken", obs_pt, e_pt);
        check("upd_rdy", obs_urdy, e_urdy);
`ifdef PHT_STATS_EN
        check("stat_upd", stat_upd_cnt, mdl_upd_cnt);
        check("stat_force", stat_force_cnt, mdl_force_cnt);
`endif
        @(posedge clk);
        #1;
        if (!run) begin
            mdl_init_cnt++;
            if (mdl_init_cnt == N) for (int i = 0; i < N; i++) mdl_ctr[i] = CTR_INIT;
        end else begin
            if (drain) begin
                if (mdl_buf_taken) mdl_ctr[mdl_buf_idx] = (mdl_ctr[mdl_buf_idx] + 1 > CTR_MAX) ? CTR_MAX : mdl_ctr[mdl_buf_idx] + 1;
                else               mdl_ctr[mdl_buf_idx] = (mdl_ctr[mdl_buf_idx] - 1 < 0) ? 0 : mdl_ctr[mdl_buf_idx] - 1;
                mdl_buf_full = 0;
                mdl_stall    = 0;
                mdl_upd_cnt++;
                if (frc) mdl_force_cnt++;
            end else if (mdl_buf_full && pv) begin
                mdl_stall++;
            end
            if (uv && e_urdy) begin
                mdl_buf_full  = 1;
                mdl_buf_idx   = ui;
                mdl_buf_taken = ut;
            end
        end
    endtask

    task automatic train(input int idx, input bit taken);
        cycle(0, 0, 1, idx, taken);
        cycle(0, 0, 0, 0, 0);
    endtask

    task automatic predict(input string tag, input int idx, input bit exp);
        cycle(1, idx, 0, 0, 0);
        check(tag, obs_pt, exp);
    endtask

    initial begin
        bit          sat_t [9] = '{1, 1, 1, 0, 0, 0, 0, 1, 1};
        bit          sat_p [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 1};
        bit          bp_rdy [4] = '{1, 0, 1, 0};
        int          bp_idx [4] = '{1, 2, 2, 4};
        int unsigned upd0, frc0;
        bit          req_v;
        int          req_i;
        bit          req_t;

        reset = 1'b1;
        bus.pred_val = 1'b0; bus.pred_idx = '0;
        bus.upd_val = 1'b0;  bus.upd_idx = '0; bus.upd_taken = 1'b0;
        #1;
        reset_dut(1);

        // Init sweep takes exactly N cycles; every entry then reads weakly not-taken.
        for (int k = 0; k <= N; k++) begin
            cycle(0, 0, 0, 0, 0);
            check("init_seq", obs_init, (k >= N));
        end
        for (int i = 0; i < N; i++) predict("init_pred", i, 0);

        // Saturation on idx 5: up to the top, down to the floor, and back.
        for (int s = 0; s < 9; s++) begin
            train(5, sat_t[s]);
            predict("sat_pred", 5, sat_p[s]);
        end

        // Backpressure: the buffer accepts at most every other cycle.
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 1, bp_idx[k], 1);
            check("bp_upd_rdy", obs_urdy, bp_rdy[k]);
        end
        cycle(0, 0, 0, 0, 0);
        predict("bp_idx1", 1, 1);
        predict("bp_idx2", 2, 1);
        predict("bp_idx4", 4, 0);

        // Starvation: continuous predictions hold off the drain until the forced cycle.
`ifdef PHT_STATS_EN
        upd0 = stat_upd_cnt;
        frc0 = stat_force_cnt;
`else
        upd0 = 0;
        frc0 = 0;
`endif
        cycle(0, 0, 1, 3, 1);
        for (int k = 0; k < 6; k++) begin
            cycle(1, 3, 0, 0, 0);
            check("starve_pred_rdy", obs_prdy, (k != 4));
            check("starve_pred_taken", obs_pt, (k == 5));
        end
`ifdef PHT_STATS_EN
        cycle(0, 0, 0, 0, 0);
        check("starve_stat_upd", stat_upd_cnt - upd0, 1);
        check("starve_stat_force", stat_force_cnt - frc0, 1);
`endif

        // Reset mid-run discards training and any pending buffer entry.
        train(7, 1);
        train(7, 1);
        predict("pre_rst_idx7", 7, 1);
        cycle(0, 0, 1, 6, 1);
        reset_dut(1);
        for (int k = 0; k <= N; k++) begin
            cycle(0, 0, 0, 0, 0);
            check("reinit_seq", obs_init, (k >= N));
        end
        cycle(0, 0, 0, 0, 0);
        predict("post_rst_idx7", 7, 0);
        predict("post_rst_idx6", 6, 0);

        // Random traffic; the producer holds each update until it is accepted.
        req_v = 0;
        req_i = 0;
        req_t = 0;
        for (int k = 0; k < 600; k++) begin
            if (!req_v && $urandom_range(0, 1) == 1) begin
                req_v = 1;
                req_i = $urandom_range(0, N - 1);
                req_t = 1'($urandom_range(0, 1));
            end
            cycle(($urandom_range(0, 3) != 0), $urandom_range(0, N - 1), req_v, req_i, req_t);
            if (req_v && obs_urdy) req_v = 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
